// File: rtl/otter_alu_pkg.sv
// Shared types for the sequential OTTER ALU.
//   alu_fun_t : the eleven ALU_FUN operation codes
//   state_t   : sequencing states of otter_alu_seq
//   is_shift  : true for the codes that run through the bit-serial shifter
package otter_alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] fun);
        return (fun == ALU_SLL) || (fun == ALU_SRL) || (fun == ALU_SRA);
    endfunction

endpackage

// File: rtl/otter_alu_seq_core.sv
// alu_core: combinational single-cycle part of the OTTER ALU.
//   a, b   : operands
//   fun    : ALU_FUN code
//   result : add/sub/slt/sltu/and/or/xor/lui result; shift codes and
//            undefined codes give 0 (shifts are sequenced by the parent)
module alu_core
    import otter_alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      fun,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (fun)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_LUI:  result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/otter_alu_seq.sv
// otter_alu_seq: multi-cycle ALU responder for the OTTER datapath.
// Non-shift ops finish one edge after acceptance; shifts move one bit
// position per cycle so only a 1-bit shifter is needed.
//   CLK, RST : clock, asynchronous active-high reset
//   START    : request strobe, accepted whenever BUSY=0
//   A, B     : operands (shift amount = B[4:0])
//   ALU_FUN  : operation code
//   BUSY     : high while a shift is running (START dropped)
//   DONE     : one-cycle completion strobe
//   ALU_OUT  : registered result, held until the next completion
module otter_alu_seq
    import otter_alu_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALU_FUN,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] ALU_OUT
);

    state_t               state_reg,     state_next;
    logic [XLEN-1:0]      work_reg,      work_next;
    logic [SHAMT_W-1:0]   cnt_reg,       cnt_next;
    logic [3:0]           shift_fun_reg, shift_fun_next;
    logic [XLEN-1:0]      alu_out_reg,   alu_out_next;

    logic [XLEN-1:0]      core_result;
    logic [XLEN-1:0]      shifted;
    logic [SHAMT_W-1:0]   shamt;

    assign shamt = B[SHAMT_W-1:0];

    alu_core u_core (
        .a      (A),
        .b      (B),
        .fun    (ALU_FUN),
        .result (core_result)
    );

    // One-position step of the serial shifter, direction taken from the
    // code latched at acceptance.
    always_comb begin
        case (shift_fun_reg)
            ALU_SLL: shifted = {work_reg[XLEN-2:0], 1'b0};
            ALU_SRL: shifted = {1'b0, work_reg[XLEN-1:1]};
            default: shifted = {work_reg[XLEN-1], work_reg[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        work_next      = work_reg;
        cnt_next       = cnt_reg;
        shift_fun_next = shift_fun_reg;
        alu_out_next   = alu_out_reg;

        case (state_reg)
            SHIFT: begin
                work_next = shifted;
                cnt_next  = cnt_reg - 5'd1;
                if (cnt_reg == 5'd1) begin
                    alu_out_next = shifted;
                    state_next   = FIN;
                end
            end
            default: begin
                // IDLE and FIN accept identically; FIN falls back to IDLE.
                if (state_reg == FIN) begin
                    state_next = IDLE;
                end
                if (START) begin
                    if (is_shift(ALU_FUN) && (shamt != '0)) begin
                        work_next      = A;
                        cnt_next       = shamt;
                        shift_fun_next = ALU_FUN;
                        state_next     = SHIFT;
                    end else begin
                        // A zero-distance shift is just a copy of A.
                        alu_out_next = is_shift(ALU_FUN) ? A : core_result;
                        state_next   = FIN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            cnt_reg       <= '0;
            shift_fun_reg <= '0;
            alu_out_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            work_reg      <= work_next;
            cnt_reg       <= cnt_next;
            shift_fun_reg <= shift_fun_next;
            alu_out_reg   <= alu_out_next;
        end
    end

    assign BUSY    = (state_reg == SHIFT);
    assign DONE    = (state_reg == FIN);
    assign ALU_OUT = alu_out_reg;

endmodule
